// File: rtl/ibn_wb_loader.sv
// Wishbone slave feeding a command FIFO to the ibnalhaytham core and holding its single result word.
// Define IBN_LOADER_IRQ_EN to drive irq from a registered copy of res_full; otherwise irq is tied low.
module ibn_wb_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic [31:0] res_data,
    input  logic        res_valid,
    output logic        irq
);
    localparam int         PW         = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [1:0] REG_CMD  = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_RES  = 2'd3;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [PW:0]   r_count;
    logic          r_ovf;
    logic          r_ack;
    logic [31:0]   r_datOut;
    logic [31:0]   r_resReg;
    logic          r_resFull;

    logic          w_hit;
    logic          w_wrHit;
    logic          w_rdHit;
    logic [1:0]    w_regSel;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_pushOk;
    logic          w_overflow;
    logic          w_flush;
    logic          w_clrOvf;
    logic          w_resRead;
    logic [31:0]   w_stat;
    logic [31:0]   w_rdData;
    logic          w_unused;

    // The !ack term keeps a held strobe from re-hitting, so every access takes two cycles.
    assign w_hit    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~r_ack;
    assign w_wrHit  = w_hit & wbs_we_i;
    assign w_rdHit  = w_hit & ~wbs_we_i;
    assign w_regSel = wbs_adr_i[3:2];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_COUNT);
    assign w_push     = w_wrHit & (w_regSel == REG_CMD);
    assign w_pop      = ~w_empty & cmd_ready;
    assign w_flush    = w_wrHit & (w_regSel == REG_CTRL) & wbs_dat_i[0];
    assign w_clrOvf   = w_wrHit & (w_regSel == REG_CTRL) & wbs_dat_i[1];
    assign w_pushOk   = w_push & (~w_full | w_pop) & ~w_flush;
    assign w_overflow = w_push & w_full & ~w_pop & ~w_flush;
    assign w_resRead  = w_rdHit & (w_regSel == REG_RES);

    assign w_stat   = {16'b0, 8'(r_count), 4'b0, r_resFull, r_ovf, w_full, w_empty};
    assign w_unused = ^{wbs_sel_i, wbs_adr_i[1:0]};

    assign cmd_valid = ~w_empty;
    assign cmd_data  = w_empty ? 32'b0 : r_mem[r_rdPtr];
    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_datOut;

    always_comb begin
        w_rdData = 32'b0;
        case (w_regSel)
            REG_STAT: w_rdData = w_stat;
            REG_RES:  w_rdData = r_resReg;
            default:  w_rdData = 32'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_datOut <= 32'b0;
        end else begin
            r_ack    <= w_hit;
            r_datOut <= w_rdHit ? w_rdData : 32'b0;
        end
    end

    // Storage carries no reset; the empty flag masks stale contents from cmd_data.
    always_ff @(posedge wb_clk_i) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= wbs_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_pushOk) begin
                    r_wrPtr <= r_wrPtr + PW'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PW'(1);
                end
                case ({w_pushOk, w_pop})
                    2'b10:   r_count <= r_count + (PW + 1)'(1);
                    2'b01:   r_count <= r_count - (PW + 1)'(1);
                    default: r_count <= r_count;
                endcase
            end
            if (w_clrOvf) begin
                r_ovf <= 1'b0;
            end else if (w_overflow) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // A result arriving alongside a RES read wins: the read sees the old word, the flag stays set.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_resReg  <= 32'b0;
            r_resFull <= 1'b0;
        end else if (res_valid) begin
            r_resReg  <= res_data;
            r_resFull <= 1'b1;
        end else if (w_resRead) begin
            r_resFull <= 1'b0;
        end
    end

`ifdef IBN_LOADER_IRQ_EN
    logic r_irq;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_resFull;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule
